exhaustive_tester: RTL and testbench

EXHAUSTIVE_TESTER -- requirements
Module: exhaustive_tester

---
 rtl/exhaustive_tester_pkg.sv | 13 +
 rtl/exhaustive_tester_if.sv | 31 +++
 rtl/exhaustive_tester_dwell_timer.sv | 28 ++
 rtl/exhaustive_tester.sv | 90 +++++++++
 tb/tb_exhaustive_tester.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_tester_pkg.sv
// rtl/exhaustive_tester_pkg.sv - shared state enum and default constants for the exhaustive tester
package exhaustive_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_IN_DEF  = 3;
  localparam int DWELL_DEF = 2;

endpackage

// File: rtl/exhaustive_tester_if.sv
// rtl/exhaustive_tester_if.sv - control, truth-table and stimulus/response bundle for the exhaustive tester
interface exhaustive_tester_if
  import exhaustive_tester_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);

  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   exp_tt;
  logic                 resp;
  logic [N_IN-1:0]      stim;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   captured;
  logic [N_IN:0]        mismatch_cnt;
  logic                 pass;

  // Controller / function-under-test side
  modport master (
    output start, abort, exp_tt, resp,
    input  stim, busy, done, captured, mismatch_cnt, pass
  );

  // Tester side
  modport slave (
    input  start, abort, exp_tt, resp,
    output stim, busy, done, captured, mismatch_cnt, pass
  );

endinterface

// File: rtl/exhaustive_tester_dwell_timer.sv
// rtl/exhaustive_tester_dwell_timer.sv - counts dwell cycles and strobes on the last one of each period
module dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [7:0] cnt;

  // last is high during the final cycle of each DWELL-cycle period
  assign last = en && (cnt == 8'(DWELL - 1));

  // Free-running period counter, restarted by clr and wrapped on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/exhaustive_tester.sv
// rtl/exhaustive_tester.sv - sweeps all stimulus vectors, captures responses and compares to a truth table
module exhaustive_tester
  import exhaustive_tester_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  exhaustive_tester_if.slave bus
);

  localparam int              NV       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  state_t          state;
  logic [NV-1:0]   exp_q;
  logic            dwell_last;
  logic            miss;
  logic [N_IN:0]   mm_next;

  // Response check against the truth table latched at start, so mid-sweep exp_tt edits are invisible
  assign miss    = bus.resp ^ exp_q[bus.stim];
  assign mm_next = bus.mismatch_cnt + (N_IN + 1)'(miss);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != SWEEP) || bus.abort),
    .en    (state == SWEEP),
    .last  (dwell_last)
  );

  // Sweep sequencer; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      exp_q            <= '0;
      bus.stim         <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.captured     <= '0;
      bus.mismatch_cnt <= '0;
      bus.pass         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q            <= bus.exp_tt;
            bus.captured     <= '0;
            bus.mismatch_cnt <= '0;
            bus.pass         <= 1'b0;
            bus.stim         <= '0;
            bus.busy         <= 1'b1;
            state            <= SWEEP;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            bus.stim <= '0;
            bus.busy <= 1'b0;
            bus.pass <= 1'b0;
            state    <= IDLE;
          end else if (dwell_last) begin
            bus.captured[bus.stim] <= bus.resp;
            bus.mismatch_cnt       <= mm_next;
            if (bus.stim == LAST_IDX) begin
              // Terminal index leaves SWEEP, so the index never wraps
              bus.stim <= '0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (mm_next == '0);
              state    <= DONE;
            end else begin
              bus.stim <= bus.stim + N_IN'(1);
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_tester.sv
// tb/tb_exhaustive_tester.sv - self-checking bench for exhaustive_tester with a result scoreboard
module tb_exhaustive_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exhaustive_tester_if #(.N_IN(3)) if3 ();
  exhaustive_tester_if #(.N_IN(4)) if4 ();

  exhaustive_tester #(.N_IN(3), .DWELL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  exhaustive_tester #(.N_IN(4), .DWELL(1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  // Test controls
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ett = 16'h0;
  int          mode = 0;

  // Muxed view of the selected DUT
  logic [3:0]  stim_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] cap_m;
  logic [4:0]  mm_m;

  int n_checks = 0;
  int n_fail = 0;

  // 0 majority, 1 parity, 2 constant one, 3 lsb
  function automatic logic resp_fn(input int m, input logic [3:0] s);
    case (m)
      0:       return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
      1:       return ^s;
      2:       return 1'b1;
      default: return s[0];
    endcase
  endfunction

  always_comb begin
    if3.start  = start & ~sel;
    if3.abort  = abort & ~sel;
    if3.exp_tt = ett[7:0];
    if3.resp   = resp_fn(mode, {1'b0, if3.stim});
    if4.start  = start & sel;
    if4.abort  = abort & sel;
    if4.exp_tt = ett;
    if4.resp   = resp_fn(mode, if4.stim);
    if (sel) begin
      stim_m = if4.stim;
      busy_m = if4.busy;
      done_m = if4.done;
      pass_m = if4.pass;
      cap_m  = if4.captured;
      mm_m   = if4.mismatch_cnt;
    end else begin
      stim_m = {1'b0, if3.stim};
      busy_m = if3.busy;
      done_m = if3.done;
      pass_m = if3.pass;
      cap_m  = {8'h00, if3.captured};
      mm_m   = {1'b0, if3.mismatch_cnt};
    end
  end

  typedef struct {
    bit          sel;
    logic [15:0] ett;
    int          mode;
    bit          abort_on_start;
    bit          repulse;
    logic [15:0] cap;
    int          mm;
    bit          pass;
  } vec_t;

  vec_t tbl[8];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One full sweep; returns on the cycle done is seen, so back-to-back calls start on the cycle after done
  task automatic run_vec(input vec_t v);
    int nb, nd, dc, se, dwell;
    vec_t e;
    nb = 0; nd = 0; dc = 0; se = 0;
    dwell = v.sel ? 1 : 2;
    @(negedge clk);
    check("done_single_cycle", {31'd0, done_m}, 32'd0);
    sel   = v.sel;
    mode  = v.mode;
    ett   = v.ett;
    start = 1'b1;
    abort = v.abort_on_start;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = (v.repulse && c == 5);
      if (v.repulse && c == 6) ett = ~v.ett;
      if (busy_m) begin
        nb++;
        if (int'(stim_m) != (c - 1) / dwell) se++;
      end
      if (done_m) begin
        nd++;
        dc = c;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got done, want no output");
        end else begin
          e = sb.pop_front();
          check("sb_captured", {16'd0, cap_m}, {16'd0, e.cap});
          check("sb_mismatch_cnt", {27'd0, mm_m}, e.mm);
          check("sb_pass", {31'd0, pass_m}, {31'd0, e.pass});
        end
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", nb, 16);
    check("done_count", nd, 1);
    check("done_cycle", dc, 17);
    check("stim_sequence_errors", se, 0);
  endtask

  initial begin
    bit found;
    tbl[0] = '{1'b0, 16'h00E8, 0, 1'b0, 1'b0, 16'h00E8, 0,  1'b1};
    tbl[1] = '{1'b0, 16'h00E9, 0, 1'b0, 1'b0, 16'h00E8, 1,  1'b0};
    tbl[2] = '{1'b0, 16'h00E8, 0, 1'b0, 1'b1, 16'h00E8, 0,  1'b1};
    tbl[3] = '{1'b0, 16'h0017, 0, 1'b0, 1'b0, 16'h00E8, 8,  1'b0};
    tbl[4] = '{1'b0, 16'h00E8, 2, 1'b1, 1'b0, 16'h00FF, 4,  1'b0};
    tbl[5] = '{1'b0, 16'h00E8, 3, 1'b0, 1'b0, 16'h00AA, 2,  1'b0};
    tbl[6] = '{1'b1, 16'h6996, 1, 1'b0, 1'b0, 16'h6996, 0,  1'b1};
    tbl[7] = '{1'b1, 16'h9669, 1, 1'b0, 1'b0, 16'h6996, 16, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stim", {28'd0, stim_m}, 32'd0);
    check("rst_busy", {31'd0, busy_m}, 32'd0);
    check("rst_done", {31'd0, done_m}, 32'd0);
    check("rst_captured", {16'd0, cap_m}, 32'd0);
    check("rst_mismatch_cnt", {27'd0, mm_m}, 32'd0);
    check("rst_pass", {31'd0, pass_m}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Abort at stim=3 after a passing sweep
    run_vec(tbl[0]);
    sel = 1'b0; mode = 2; ett = 16'h00E8;
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy_m && stim_m == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_stim3", {31'd0, found}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy_m}, 32'd0);
    check("abort_stim", {28'd0, stim_m}, 32'd0);
    check("abort_done", {31'd0, done_m}, 32'd0);
    check("abort_pass", {31'd0, pass_m}, 32'd0);
    check("abort_captured", {16'd0, cap_m}, 32'h07);
    check("abort_mismatch_cnt", {27'd0, mm_m}, 32'd3);
    // abort held in IDLE is ignored and results hold
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_abort_no_done", {31'd0, done_m | busy_m}, 32'd0);
    end
    check("idle_hold_captured", {16'd0, cap_m}, 32'h07);
    check("idle_hold_mismatch_cnt", {27'd0, mm_m}, 32'd3);
    abort = 1'b0;

    // Asynchronous reset mid-sweep
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy_m}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy_m}, 32'd0);
    check("async_rst_stim", {28'd0, stim_m}, 32'd0);
    check("async_rst_captured", {16'd0, cap_m}, 32'd0);
    check("async_rst_mismatch_cnt", {27'd0, mm_m}, 32'd0);
    check("async_rst_pass_done", {31'd0, pass_m | done_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {31'd0, busy_m}, 32'd0);
    end
    run_vec(tbl[0]);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
